// File: rtl/q_update_ctrl_if.sv
// Request, Q-table RAM and Q_updater signal bundle for q_update_ctrl.
// slave is the controller's view; master is the requester/RAM/updater side.
interface q_update_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int STATE_W = 15,
  parameter int ADDR_W  = 18
);
  logic               start;
  logic [STATE_W-1:0] state_idx;
  logic [3:0]         action;
  logic [STATE_W-1:0] next_idx;
  logic               terminal;
  logic [DATA_W-1:0]  reward;
  logic [DATA_W-1:0]  gamma_cfg;
  logic [DATA_W-1:0]  alfa_cfg;
  logic               mem_rd_en;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wr_data;
  logic [DATA_W-1:0]  mem_rd_data;
  logic [DATA_W-1:0]  upd_q;
  logic [DATA_W-1:0]  upd_max_q;
  logic [DATA_W-1:0]  upd_reward;
  logic [DATA_W-1:0]  upd_gamma;
  logic [DATA_W-1:0]  upd_alfa;
  logic [DATA_W-1:0]  upd_q_new;
  logic               busy;
  logic               done;
  logic               err;
  logic [DATA_W-1:0]  q_new_out;

  modport slave (
    input  start, state_idx, action, next_idx, terminal, reward, gamma_cfg, alfa_cfg,
           mem_rd_data, upd_q_new,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
           upd_q, upd_max_q, upd_reward, upd_gamma, upd_alfa,
           busy, done, err, q_new_out
  );

  modport master (
    output start, state_idx, action, next_idx, terminal, reward, gamma_cfg, alfa_cfg,
           mem_rd_data, upd_q_new,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
           upd_q, upd_max_q, upd_reward, upd_gamma, upd_alfa,
           busy, done, err, q_new_out
  );
endinterface

// File: rtl/q_update_ctrl.sv
// Sequencer for one Q-learning update: read Q(s,a), scan the row of s' for max_Q,
// register the updater result and write it back to Q(s,a).
module q_update_ctrl #(
  parameter int DATA_W      = 16,
  parameter int NUM_ACTIONS = 9,
  parameter int STATE_W     = 15,
  parameter int ADDR_W      = 18
) (
  input logic            clk,
  input logic            rst_n,
  q_update_ctrl_if.slave bus
);
  localparam int K_W = $clog2(NUM_ACTIONS + 1);

  typedef enum logic [2:0] {IDLE, RD_Q, SCAN, DRAIN, CALC, WR, DONE} state_t;
  state_t state, state_nx;

  logic [K_W-1:0]            k;
  logic [STATE_W-1:0]        s_reg, ns_reg;
  logic [3:0]                a_reg;
  logic                      term_reg, err_reg;
  logic [DATA_W-1:0]         rew_reg, gam_reg, alf_reg, qn_reg, qn_out_reg;
  logic signed [DATA_W-1:0]  q_reg, max_reg, rd_s;
  logic [ADDR_W-1:0]         sa_addr, scan_addr, addr;
  logic                      rd_en, wr_en, bad_act, last_k;

  assign rd_s      = bus.mem_rd_data;
  assign bad_act   = 32'(bus.action) >= NUM_ACTIONS;
  assign last_k    = 32'(k) == NUM_ACTIONS - 1;
  assign sa_addr   = ADDR_W'(s_reg) * ADDR_W'(NUM_ACTIONS) + ADDR_W'(a_reg);
  assign scan_addr = ADDR_W'(ns_reg) * ADDR_W'(NUM_ACTIONS) + ADDR_W'(k);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    addr     = '0;
    case (state)
      IDLE:  if (bus.start) state_nx = bad_act ? DONE : RD_Q;
      RD_Q:  begin
        rd_en    = 1'b1;
        addr     = sa_addr;
        state_nx = term_reg ? DRAIN : SCAN;
      end
      SCAN:  begin
        rd_en = 1'b1;
        addr  = scan_addr;
        if (last_k) state_nx = DRAIN;
      end
      DRAIN: state_nx = CALC;
      CALC:  state_nx = WR;
      WR:    begin
        wr_en    = 1'b1;
        addr     = sa_addr;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read data lags the address by one cycle: SCAN k sees word k-1 (k=0 sees Q(s,a)).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k          <= '0;
      s_reg      <= '0;
      ns_reg     <= '0;
      a_reg      <= '0;
      term_reg   <= 1'b0;
      err_reg    <= 1'b0;
      rew_reg    <= '0;
      gam_reg    <= '0;
      alf_reg    <= '0;
      q_reg      <= '0;
      max_reg    <= '0;
      qn_reg     <= '0;
      qn_out_reg <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          s_reg    <= bus.state_idx;
          ns_reg   <= bus.next_idx;
          a_reg    <= bus.action;
          term_reg <= bus.terminal;
          rew_reg  <= bus.reward;
          gam_reg  <= bus.gamma_cfg;
          alf_reg  <= bus.alfa_cfg;
          err_reg  <= bad_act;
          k        <= '0;
        end
        SCAN: begin
          k <= k + K_W'(1);
          if (k == '0) q_reg <= rd_s;
          else if (k == K_W'(1) || rd_s > max_reg) max_reg <= rd_s;
        end
        DRAIN: begin
          if (term_reg) begin
            q_reg   <= rd_s;
            max_reg <= '0;
          end else if (NUM_ACTIONS == 1 || rd_s > max_reg) begin
            max_reg <= rd_s;
          end
        end
        CALC: qn_reg <= bus.upd_q_new;
        WR:   qn_out_reg <= qn_reg;
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_addr    = addr;
  assign bus.mem_wr_data = qn_reg;
  assign bus.upd_q       = q_reg;
  assign bus.upd_max_q   = max_reg;
  assign bus.upd_reward  = rew_reg;
  assign bus.upd_gamma   = gam_reg;
  assign bus.upd_alfa    = alf_reg;
  assign bus.busy        = state != IDLE;
  assign bus.done        = state == DONE;
  assign bus.err         = (state == DONE) && err_reg;
  assign bus.q_new_out   = qn_out_reg;
endmodule

// File: tb/tb_q_update_ctrl.sv
// Self-checking bench for q_update_ctrl: RAM and updater models around the DUT,
// expected results computed from the row contents with plain arithmetic.
module tb_q_update_ctrl;
  localparam int DW = 16, NA = 9, SW = 15, AW = 18;
  localparam int RAM_N = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  q_update_ctrl_if #(.DATA_W(DW), .STATE_W(SW), .ADDR_W(AW)) bus ();

  q_update_ctrl #(.DATA_W(DW), .NUM_ACTIONS(NA), .STATE_W(SW), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] ram [RAM_N];
  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] upd_fn(input logic [15:0] q, mx, r, g, al);
    int qi, mi, ri, t;
    qi = int'($signed(q));
    mi = int'($signed(mx));
    ri = int'($signed(r));
    t  = ri + (mi >>> g[3:0]) - qi;
    return 16'(qi + (t >>> al[3:0]));
  endfunction

  function automatic logic [15:0] row_max(input int ns);
    int m;
    m = int'($signed(ram[ns * NA]));
    for (int j = 1; j < NA; j++)
      if (int'($signed(ram[ns * NA + j])) > m) m = int'($signed(ram[ns * NA + j]));
    return 16'(m);
  endfunction

  assign bus.upd_q_new = upd_fn(bus.upd_q, bus.upd_max_q, bus.upd_reward, bus.upd_gamma, bus.upd_alfa);

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[int'(bus.mem_addr)];
    if (bus.mem_wr_en) ram[int'(bus.mem_addr)] <= bus.mem_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input int a, input int ns, input bit term,
                       input logic [15:0] rew, input logic [15:0] g, input logic [15:0] al);
    bus.state_idx = SW'(s);
    bus.action    = 4'(a);
    bus.next_idx  = SW'(ns);
    bus.terminal  = term;
    bus.reward    = rew;
    bus.gamma_cfg = g;
    bus.alfa_cfg  = al;
  endtask

  task automatic run_req(input string tag, input int s, input int a, input int ns, input bit term,
                         input logic [15:0] rew, input logic [15:0] g, input logic [15:0] al);
    logic [15:0] eq, emax, eqn, wd;
    int lat, erd, nrd, nwr, done_n, wa;
    bit errc, strobe_bad;
    errc = a >= NA;
    eq = '0; emax = '0; eqn = '0;
    if (!errc) begin
      eq   = ram[s * NA + a];
      emax = term ? 16'h0 : row_max(ns);
      eqn  = upd_fn(eq, emax, rew, g, al);
    end
    lat = errc ? 1 : (term ? 5 : 5 + NA);
    erd = errc ? 0 : (term ? 1 : 1 + NA);
    @(negedge clk);
    drive(s, a, ns, term, rew, g, al);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    nrd = 0; nwr = 0; done_n = 0; wa = 0; wd = '0; strobe_bad = 1'b0;
    for (int n = 1; n <= 40 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      if (bus.mem_rd_en) nrd++;
      if (bus.mem_wr_en) begin
        nwr++;
        wa = int'(bus.mem_addr);
        wd = bus.mem_wr_data;
      end
      if (bus.mem_rd_en && bus.mem_wr_en) strobe_bad = 1'b1;
      if (!bus.mem_rd_en && !bus.mem_wr_en && bus.mem_addr != '0) strobe_bad = 1'b1;
      if (bus.done) begin
        done_n = n;
        chk({tag, ".err"}, 32'(bus.err), 32'(errc));
        if (!errc) begin
          chk({tag, ".upd_q"}, 32'(bus.upd_q), 32'(eq));
          chk({tag, ".max_q"}, 32'(bus.upd_max_q), 32'(emax));
          chk({tag, ".q_new_out"}, 32'(bus.q_new_out), 32'(eqn));
        end
      end
    end
    chk({tag, ".latency"}, 32'(done_n), 32'(lat));
    chk({tag, ".reads"}, 32'(nrd), 32'(erd));
    chk({tag, ".writes"}, 32'(nwr), errc ? 32'd0 : 32'd1);
    chk({tag, ".strobes"}, 32'(strobe_bad), 32'd0);
    if (!errc) begin
      chk({tag, ".wr_addr"}, 32'(wa), 32'((s * NA + a) % RAM_N));
      chk({tag, ".wr_data"}, 32'(wd), 32'(eqn));
    end
    @(negedge clk);
    chk({tag, ".idle"}, 32'({bus.busy, bus.done}), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".ctl"}, 32'({bus.busy, bus.done, bus.err, bus.mem_rd_en, bus.mem_wr_en}), 32'd0);
    chk({tag, ".addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, ".wr_data"}, 32'(bus.mem_wr_data), 32'd0);
    chk({tag, ".upd"}, {bus.upd_q, bus.upd_max_q}, 32'd0);
    chk({tag, ".upd_cfg"}, 32'(bus.upd_reward | bus.upd_gamma | bus.upd_alfa), 32'd0);
    chk({tag, ".q_new_out"}, 32'(bus.q_new_out), 32'd0);
  endtask

  initial begin
    logic [15:0] chain [3];
    logic [15:0] wlog [$];
    int done_at [$];
    int nwr;
    bit wr_seen;
    logic [15:0] row7 [NA];
    logic [15:0] rowneg [NA];

    for (int i = 0; i < RAM_N; i++) ram[i] = 16'($urandom);
    bus.mem_rd_data = '0;
    bus.start = 1'b0;
    drive(0, 0, 0, 1'b0, 16'h0, 16'h0, 16'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset0");
    rst_n = 1'b1;

    // Directed non-terminal example: Q(5,2)=100, row of 7 peaks at index 1.
    row7 = '{16'hFFFD, 16'd40, 16'd40, 16'd7, 16'd0, 16'hFF9C, 16'd12, 16'd39, 16'd1};
    ram[5 * NA + 2] = 16'd100;
    for (int j = 0; j < NA; j++) ram[7 * NA + j] = row7[j];
    run_req("nonterm", 5, 2, 7, 1'b0, 16'd10, 16'd1, 16'd2);

    run_req("terminal", 0, 4, 300, 1'b1, 16'd256, 16'd1, 16'd1);

    rowneg = '{16'hFFFB, 16'hFFF7, 16'hFFF9, 16'hFFFA, 16'hFFF8, 16'hFFF6, 16'hFFF5, 16'hFFFC, 16'hFFFE};
    for (int j = 0; j < NA; j++) ram[11 * NA + j] = rowneg[j];
    run_req("allneg", 10, 0, 11, 1'b0, 16'hFFF0, 16'd2, 16'd3);

    for (int j = 0; j < NA; j++) ram[12 * NA + j] = 16'h8000;
    run_req("allmin", 13, 8, 12, 1'b0, 16'd5, 16'd0, 16'd1);

    run_req("err9", 3, 9, 4, 1'b0, 16'd1, 16'd1, 16'd1);
    run_req("err15", 3, 15, 4, 1'b1, 16'd1, 16'd1, 16'd1);

    for (int r = 0; r < 16; r++) begin
      int s, a, ns;
      s  = int'($urandom_range(19682));
      a  = ($urandom_range(7) == 0) ? int'($urandom_range(15, 9)) : int'($urandom_range(8));
      ns = int'($urandom_range(19682));
      run_req($sformatf("rand%0d", r), s, a, ns, 1'($urandom_range(3) == 0),
              16'($urandom), 16'($urandom_range(15)), 16'($urandom_range(7)));
    end

    // Reset mid-SCAN: nothing may be written, everything returns to zero.
    @(negedge clk);
    drive(40, 1, 41, 1'b0, 16'd7, 16'd1, 16'd1);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    wr_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_wr_en) wr_seen = 1'b1;
    end
    chk_zero_outputs("midreset");
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_wr_en || bus.busy) wr_seen = 1'b1;
    end
    chk("midreset.quiet", 32'(wr_seen), 32'd0);
    run_req("after_reset", 40, 1, 41, 1'b0, 16'd7, 16'd1, 16'd1);

    // start held high: three updates of the same entry, each a fresh acceptance.
    chain[0] = upd_fn(ram[20 * NA + 3], row_max(21), 16'd50, 16'd1, 16'd1);
    chain[1] = upd_fn(chain[0], row_max(21), 16'd50, 16'd1, 16'd1);
    chain[2] = upd_fn(chain[1], row_max(21), 16'd50, 16'd1, 16'd1);
    @(negedge clk);
    drive(20, 3, 21, 1'b0, 16'd50, 16'd1, 16'd1);
    bus.start = 1'b1;
    @(posedge clk);
    nwr = 0;
    for (int n = 1; n <= 100 && done_at.size() < 3; n++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        nwr++;
        wlog.push_back(bus.mem_wr_data);
      end
      if (bus.done) done_at.push_back(n);
    end
    bus.start = 1'b0;
    chk("held.dones", 32'(done_at.size()), 32'd3);
    chk("held.writes", 32'(nwr), 32'd3);
    if (done_at.size() == 3) begin
      chk("held.first", 32'(done_at[0]), 32'd14);
      chk("held.gap1", 32'(done_at[1] - done_at[0]), 32'd15);
      chk("held.gap2", 32'(done_at[2] - done_at[1]), 32'd15);
    end
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      chk($sformatf("held.wdata%0d", i), 32'(wlog[i]), 32'(chain[i]));
    chk("held.q_new_out", 32'(bus.q_new_out), 32'(chain[2]));

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
